if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Holds the PC, issues in-order word
//               fetches to instruction memory, buffers returned words in a
//               BUF_DEPTH-entry circular queue and presents them to decode
//               with a valid/ready handshake. Redirects flush the queue and
//               discard responses that belong to wrong-path fetches.
//               Optional macro FETCH_PERF_CNT_EN adds perf_fetched and
//               perf_bubbles saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory request/response
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    // redirect from execute
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    // decode-side handshake
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_op,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DSC_W = $clog2(2 * BUF_DEPTH) + 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [DSC_W-1:0] discard_cnt_q;

    logic [BUF_DEPTH-1:0] ent_alloc_q;
    logic [BUF_DEPTH-1:0] ent_filled_q;
    logic [XLEN-1:0]      ent_pc_q    [BUF_DEPTH];
    logic [31:0]          ent_instr_q [BUF_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             fire;       // request accepted by memory this cycle
    logic             drop;       // response belongs to a flushed fetch
    logic             fill;       // response lands in a live entry
    logic             pop;        // head consumed by decode
    logic             fill_hit;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] scan_slot;
    logic [CNT_W-1:0] unfilled;
    logic [DSC_W-1:0] discard_cnt_d;
    logic [CNT_W-1:0] count_d;

    // Request issue: occupancy is checked before any same-cycle pop.
    assign imem_req  = !rst && !redirect && (count_q < CNT_W'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_ready;

    // Locate the oldest allocated-but-unfilled entry (scan from head) and
    // count all unfilled entries, which become discards on a redirect.
    always_comb begin
        fill_hit  = 1'b0;
        fill_idx  = '0;
        unfilled  = '0;
        scan_slot = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            scan_slot = head_q + PTR_W'(i);
            if (ent_alloc_q[scan_slot] && !ent_filled_q[scan_slot]) begin
                unfilled = unfilled + CNT_W'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = scan_slot;
                end
            end
        end
    end

    assign drop = imem_rvalid && (discard_cnt_q != '0);
    assign fill = imem_rvalid && !drop && fill_hit;

    // Head entry drives decode directly; nop/zero when nothing is ready.
    assign id_valid    = ent_alloc_q[head_q] && ent_filled_q[head_q];
    assign id_instr    = id_valid ? ent_instr_q[head_q] : NOP_INSTR;
    assign id_op       = id_instr[6:0];
    assign id_pc       = id_valid ? ent_pc_q[head_q] : '0;
    assign id_pc_plus4 = id_pc + XLEN'(4);

    // A pop requested in a redirect cycle is discarded with the flush.
    assign pop = id_valid && id_ready && !redirect;

    // Next discard count: a redirect turns every unfilled entry into an
    // outstanding wrong-path response, less any that return this cycle.
    always_comb begin
        discard_cnt_d = discard_cnt_q - DSC_W'(drop);
        if (redirect) begin
            discard_cnt_d = discard_cnt_d + DSC_W'(unfilled) - DSC_W'(fill);
        end
    end

    assign count_d = count_q + CNT_W'(fire) - CNT_W'(pop);

    // Queue, pointer, PC and discard-count state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            discard_cnt_q <= '0;
            ent_alloc_q   <= '0;
            ent_filled_q  <= '0;
        end else if (redirect) begin
            pc_q          <= {redirect_pc[XLEN-1:2], 2'b00};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            discard_cnt_q <= discard_cnt_d;
            ent_alloc_q   <= '0;
            ent_filled_q  <= '0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
            count_q       <= count_d;
            if (fire) begin
                ent_alloc_q[tail_q]  <= 1'b1;
                ent_filled_q[tail_q] <= 1'b0;
                ent_pc_q[tail_q]     <= pc_q;
                tail_q               <= tail_q + PTR_W'(1);
                pc_q                 <= pc_q + XLEN'(4);
            end
            if (fill) begin
                ent_filled_q[fill_idx] <= 1'b1;
                ent_instr_q[fill_idx]  <= imem_rdata;
            end
            if (pop) begin
                ent_alloc_q[head_q]  <= 1'b0;
                ent_filled_q[head_q] <= 1'b0;
                head_q               <= head_q + PTR_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    // Saturating counters of delivered instructions and starved decode cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (pop && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (id_ready && !id_valid && (perf_bubbles_q != '1)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

`ifndef SYNTHESIS
    // A response with no live target and nothing to discard is a memory
    // protocol violation; the RTL ignores it.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((discard_cnt_q != '0) || fill_hit));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Scoreboard bench for if_fetch_unit. The reference model is
//               the architectural instruction stream: decode must see
//               consecutive PCs from reset/redirect target with the memory
//               word stored at each PC. A memory model returns in-order
//               responses with random latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [6:0]  id_op;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    if_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_op       (id_op),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          c;
    } pend_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          occ     = 0;     // instructions accepted by memory, not yet popped
    int          n_acc   = 0;
    int          first_acc = -1;
    int          first_pop = -1;
    bit          mon_en  = 0;
    bit          prev_flush = 1;
    bit          mem_fast = 1;
    bit          mem_hold = 0;
    logic [31:0] fetch_exp;
    logic [31:0] exp_next;
    logic [31:0] exp_q [$];
    pend_t       pend  [$];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_fetched = 0;
    logic [31:0] m_bubbles = 0;
`endif

    // Instruction memory contents: fixed words at 0/4, hashed elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 32) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    // One clock of stimulus: control inputs, memory response, request accept.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit idr);
        @(negedge clk);
        cyc++;
        rst = r; redirect = rd; redirect_pc = rpc; id_ready = idr;
        if (r) begin
            pend.delete(); exp_q.delete();
            exp_next = RPC; refill();
            fetch_exp = RPC; occ = 0;
        end else if (rd) begin
            exp_q.delete();
            exp_next = {rpc[31:2], 2'b00}; refill();
            fetch_exp = {rpc[31:2], 2'b00}; occ = 0;
        end
        if (!r && pend.size() > 0 && pend[0].c < cyc && !mem_hold &&
            (mem_fast || $urandom_range(0, 2) != 0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend[0].a);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_ready = mem_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        if (r || rd) begin
            chk("req_blocked", {31'd0, imem_req}, 32'd0);
        end else begin
            chk("req_vs_occupancy", {31'd0, imem_req}, {31'd0, (occ < DEPTH)});
            if (imem_req && imem_ready) begin
                chk("imem_addr", imem_addr, fetch_exp);
                fetch_exp = fetch_exp + 32'd4;
                pend.push_back('{a: imem_addr, c: cyc});
                occ++; n_acc++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
    endtask

    // Monitor: samples outputs mid-cycle and scores every handshake.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (prev_flush) chk("valid_after_flush", {31'd0, id_valid}, 32'd0);
            if (!id_valid) begin
                chk("idle_instr", id_instr, 32'h0000_0013);
                chk("idle_pc", id_pc, 32'd0);
                chk("idle_pc_plus4", id_pc_plus4, 32'd4);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_bubbles", perf_bubbles, m_bubbles);
            if (rst) begin
                m_fetched = 0; m_bubbles = 0;
            end else begin
                if (id_valid && id_ready && !redirect) m_fetched++;
                if (id_ready && !id_valid) m_bubbles++;
            end
`endif
            if (!rst && !redirect && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_instr", id_instr, memf(e));
                    chk("id_op", {25'd0, id_op}, {25'd0, memf(e) & 32'h7F});
                    chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
                    refill();
                end
                occ--;
                if (first_pop < 0) first_pop = cyc;
            end
            prev_flush = rst || redirect;
        end
    end

    initial begin
        int acc0;
        rst = 1; redirect = 0; redirect_pc = 0; id_ready = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;

        // Reset, then streaming with 1-cycle memory.
        step(1, 0, 0, 1);
        @(posedge clk);
        mon_en = 1;
        step(1, 0, 0, 1);
        first_acc = -1; first_pop = -1;
        repeat (8) step(0, 0, 0, 1);
        chk("first_fetch_to_valid_latency", first_pop - first_acc, 32'd2);

        // Back-pressure: only DEPTH requests accepted while decode stalls.
        step(1, 0, 0, 0);
        acc0 = n_acc;
        repeat (5) step(0, 0, 0, 0);
        chk("stall_accepts", n_acc - acc0, DEPTH);
        chk("stall_req_low", {31'd0, imem_req}, 32'd0);
        repeat (6) step(0, 0, 0, 1);

        // Redirect to 0x100 with two fetches outstanding and unfilled.
        step(1, 0, 0, 0);
        mem_hold = 1;
        repeat (3) step(0, 0, 0, 0);
        chk("unfilled_before_redirect", pend.size(), 32'd2);
        step(0, 1, 32'h100, 0);
        mem_hold = 0;
        repeat (10) step(0, 0, 0, 1);

        // Redirect to 0x103 while a valid head is being consumed.
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        chk("head_valid_before_redirect", {31'd0, id_valid}, 32'd1);
        step(0, 1, 32'h103, 1);
        repeat (8) step(0, 0, 0, 1);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 1);
        repeat (8) step(0, 0, 0, 1);

        // Reset in mid-stream with queued instructions.
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1);

        // Randomised traffic with variable latency, redirects and resets.
        mem_fast = 0;
        for (int i = 0; i < 4000; i++) begin
            bit          r, rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 399) == 0);
            rd = !r && ($urandom_range(0, 11) == 0);
            t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h7)) : $urandom;
            step(r, rd, t, $urandom_range(0, 3) != 0);
        end
        mem_fast = 1;
        repeat (10) step(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
